// File: rtl/secure_parity_router.sv
`default_nettype none
// ============================================================================
//  Module      : secure_parity_router
//  Description : Password-gated session controller. After a successful
//                authentication each confirm press captures din and strobes
//                en_left (odd data) or en_right (even data) for one cycle.
//                Repeated failed attempts trigger a timed lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
module secure_parity_router #(
  parameter int DATA_W      = 4,
  parameter int PASS_W      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  localparam int CNT_W      = $clog2(MAX_TRIES + 1),
  localparam int TMR_W      = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              request,
  input  logic              confirm,
  input  logic [PASS_W-1:0] secret_pass,
  input  logic [PASS_W-1:0] pass_data,
  input  logic [DATA_W-1:0] din,
  output logic              en_left,
  output logic              en_right,
  output logic [DATA_W-1:0] dout,
  output logic              granted,
  output logic              locked,
  output logic [CNT_W-1:0]  attempts_left
);

  localparam logic [CNT_W-1:0] C_MAX_TRIES   = CNT_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] C_LOCK_CYCLES = TMR_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
  localparam logic [TMR_W-1:0] C_TMR_ONE     = TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AUTH    = 3'd1,
    S_GRANTED = 3'd2,
    S_ROUTE   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_confirm_q;
  logic             w_cpulse;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] w_fail_next;
  logic [CNT_W-1:0] w_fail_inc;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_next;
  logic             w_capture;

  // A held confirm only acts on its rising edge.
  assign w_cpulse = confirm & ~r_confirm_q;

  // Saturating increment of the failure count.
  assign w_fail_inc = (r_fail_cnt < C_MAX_TRIES) ? (r_fail_cnt + C_CNT_ONE) : r_fail_cnt;

  // Confirm history register for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_confirm_q <= 1'b0;
    end else begin
      r_confirm_q <= confirm;
    end
  end

  // Next-state, failure-count and lockout-timer decisions.
  always_comb begin
    w_state_next = r_state;
    w_fail_next  = r_fail_cnt;
    w_timer_next = r_timer;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (request) begin
          w_state_next = S_AUTH;
        end
      end
      S_AUTH: begin
        if (!request) begin
          w_state_next = S_IDLE;
        end else if (w_cpulse) begin
          if (pass_data == secret_pass) begin
            w_state_next = S_GRANTED;
            w_fail_next  = '0;
          end else begin
            w_fail_next = w_fail_inc;
            if (w_fail_inc == C_MAX_TRIES) begin
              w_state_next = S_LOCKOUT;
              w_timer_next = C_LOCK_CYCLES;
            end
          end
        end
      end
      S_GRANTED: begin
        if (!request) begin
          w_state_next = S_IDLE;
        end else if (w_cpulse) begin
          w_state_next = S_ROUTE;
          w_capture    = 1'b1;
        end
      end
      S_ROUTE: begin
        w_state_next = request ? S_GRANTED : S_IDLE;
      end
      S_LOCKOUT: begin
        // Inputs are ignored; leave when the timer reaches zero.
        if (r_timer != '0) begin
          w_timer_next = r_timer - C_TMR_ONE;
        end
        if (r_timer <= C_TMR_ONE) begin
          w_state_next = S_IDLE;
          w_fail_next  = '0;
          w_timer_next = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, counter and timer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fail_cnt <= '0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fail_cnt <= w_fail_next;
      r_timer    <= w_timer_next;
    end
  end

  // Outputs are registered from the next-state decision so they line up
  // with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_left       <= 1'b0;
      en_right      <= 1'b0;
      dout          <= '0;
      granted       <= 1'b0;
      locked        <= 1'b0;
      attempts_left <= C_MAX_TRIES;
    end else begin
      en_left       <= w_capture &  din[0];
      en_right      <= w_capture & ~din[0];
      if (w_capture) begin
        dout <= din;
      end
      granted       <= (w_state_next == S_GRANTED) || (w_state_next == S_ROUTE);
      locked        <= (w_state_next == S_LOCKOUT);
      attempts_left <= C_MAX_TRIES - w_fail_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_secure_parity_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_secure_parity_router
//  Description : Directed self-checking bench for secure_parity_router with a
//                queue of expected output snapshots.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_secure_parity_router;

  logic       clock;
  logic       reset;
  logic       request;
  logic       confirm;
  logic [3:0] secret_pass;
  logic [3:0] pass_data;
  logic [3:0] din;
  logic       en_left;
  logic       en_right;
  logic [3:0] dout;
  logic       granted;
  logic       locked;
  logic [1:0] attempts_left;

  int n_cmp;
  int n_err;

  typedef struct {
    string      tag;
    logic       el;
    logic       er;
    logic [3:0] d;
    logic       gr;
    logic       lk;
    logic [1:0] att;
  } exp_t;

  exp_t sb[$];

  secure_parity_router dut (
    .clock         (clock),
    .reset         (reset),
    .request       (request),
    .confirm       (confirm),
    .secret_pass   (secret_pass),
    .pass_data     (pass_data),
    .din           (din),
    .en_left       (en_left),
    .en_right      (en_right),
    .dout          (dout),
    .granted       (granted),
    .locked        (locked),
    .attempts_left (attempts_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic el, input logic er, input logic [3:0] d,
                      input logic gr, input logic lk, input logic [1:0] att);
    exp_t e;
    e.tag = tag; e.el = el; e.er = er; e.d = d; e.gr = gr; e.lk = lk; e.att = att;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".en_left"},  int'(en_left),       int'(e.el));
      cmp({e.tag, ".en_right"}, int'(en_right),      int'(e.er));
      cmp({e.tag, ".dout"},     int'(dout),          int'(e.d));
      cmp({e.tag, ".granted"},  int'(granted),       int'(e.gr));
      cmp({e.tag, ".locked"},   int'(locked),        int'(e.lk));
      cmp({e.tag, ".attempts"}, int'(attempts_left), int'(e.att));
    end
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic cyc(input string tag, input logic el, input logic er, input logic [3:0] d,
                     input logic gr, input logic lk, input logic [1:0] att);
    push(tag, el, er, d, gr, lk, att);
    @(posedge clock);
    #2;
    pop_check();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    request = 1'b0;
    confirm = 1'b0;
    secret_pass = 4'hA;
    pass_data = 4'hA;
    din = 4'h0;

    // Reset state, held across edges.
    cyc("reset0", 0, 0, 4'h0, 0, 0, 2'd3);
    cyc("reset1", 0, 0, 4'h0, 0, 0, 2'd3);
    reset = 1'b1;
    cyc("idle",   0, 0, 4'h0, 0, 0, 2'd3);

    // Authenticate and route even data.
    request = 1'b1;
    cyc("auth",      0, 0, 4'h0, 0, 0, 2'd3);
    confirm = 1'b1;
    cyc("grant",     0, 0, 4'h0, 1, 0, 2'd3);
    confirm = 1'b0; din = 4'h6;
    cyc("granted",   0, 0, 4'h0, 1, 0, 2'd3);
    confirm = 1'b1;
    cyc("route6",    0, 1, 4'h6, 1, 0, 2'd3);
    confirm = 1'b0; din = 4'h7;
    cyc("after6",    0, 0, 4'h6, 1, 0, 2'd3);

    // Odd data, then another route without re-authentication.
    confirm = 1'b1;
    cyc("route7",    1, 0, 4'h7, 1, 0, 2'd3);
    confirm = 1'b0;
    cyc("after7",    0, 0, 4'h7, 1, 0, 2'd3);
    confirm = 1'b1; din = 4'h2;
    cyc("route2",    0, 1, 4'h2, 1, 0, 2'd3);
    din = 4'h5;
    cyc("held_a",    0, 0, 4'h2, 1, 0, 2'd3);
    cyc("held_b",    0, 0, 4'h2, 1, 0, 2'd3);

    // Dropping request in GRANTED ends the session.
    confirm = 1'b0; request = 1'b0;
    cyc("drop",      0, 0, 4'h2, 0, 0, 2'd3);

    // Held confirm with wrong password counts once.
    pass_data = 4'h3; request = 1'b1;
    cyc("auth2",     0, 0, 4'h2, 0, 0, 2'd3);
    confirm = 1'b1;
    cyc("fail1",     0, 0, 4'h2, 0, 0, 2'd2);
    for (int i = 0; i < 4; i++) cyc("fail_held", 0, 0, 4'h2, 0, 0, 2'd2);

    // Failure count persists through IDLE.
    confirm = 1'b0; request = 1'b0;
    cyc("persist_idle", 0, 0, 4'h2, 0, 0, 2'd2);
    request = 1'b1;
    cyc("persist_auth", 0, 0, 4'h2, 0, 0, 2'd2);
    confirm = 1'b1;
    cyc("fail2",     0, 0, 4'h2, 0, 0, 2'd1);
    confirm = 1'b0;
    cyc("fail2_hold", 0, 0, 4'h2, 0, 0, 2'd1);
    confirm = 1'b1;
    cyc("lock_c1",   0, 0, 4'h2, 0, 1, 2'd0);

    // Lockout ignores a correct password; lasts exactly 16 cycles.
    pass_data = 4'hA;
    for (int i = 2; i <= 16; i++) begin
      confirm = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc("lock_cyc", 0, 0, 4'h2, 0, 1, 2'd0);
    end
    confirm = 1'b0;
    cyc("lock_exit", 0, 0, 4'h2, 0, 0, 2'd3);
    cyc("reauth",    0, 0, 4'h2, 0, 0, 2'd3);

    // Enter lockout again and reset asynchronously at lockout cycle 5.
    pass_data = 4'h3;
    confirm = 1'b1;
    cyc("f1",        0, 0, 4'h2, 0, 0, 2'd2);
    confirm = 1'b0;
    cyc("f1h",       0, 0, 4'h2, 0, 0, 2'd2);
    confirm = 1'b1;
    cyc("f2",        0, 0, 4'h2, 0, 0, 2'd1);
    confirm = 1'b0;
    cyc("f2h",       0, 0, 4'h2, 0, 0, 2'd1);
    confirm = 1'b1;
    cyc("lock2_c1",  0, 0, 4'h2, 0, 1, 2'd0);
    confirm = 1'b0;
    for (int i = 2; i <= 5; i++) cyc("lock2_cyc", 0, 0, 4'h2, 0, 1, 2'd0);
    reset = 1'b0;
    push("async_rst", 0, 0, 4'h0, 0, 0, 2'd3);
    #1;
    pop_check();

    // Fresh session after reset, then reset mid-session.
    pass_data = 4'hA;
    #1;
    reset = 1'b1;
    cyc("post_rst",  0, 0, 4'h0, 0, 0, 2'd3);
    confirm = 1'b1;
    cyc("grant2",    0, 0, 4'h0, 1, 0, 2'd3);
    confirm = 1'b0;
    reset = 1'b0;
    push("rst_sess", 0, 0, 4'h0, 0, 0, 2'd3);
    #1;
    pop_check();
    reset = 1'b1;
    request = 1'b0;
    cyc("final_idle", 0, 0, 4'h0, 0, 0, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
